// File: rtl/pio_scan_pkg.sv
// Shared types and constants for the PIO edge scanner.
// Define PIO_SCAN_LEVEL_EN to also capture live input levels with each event.
package pio_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_EDGE,
    ST_WAIT_EDGE,
    ST_RD_LVL,
    ST_WAIT_LVL,
    ST_CLR,
    ST_PUSH
  } scan_state_t;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

`ifdef PIO_SCAN_LEVEL_EN
  localparam bit LEVEL_EN = 1'b1;
`else
  localparam bit LEVEL_EN = 1'b0;
`endif

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pio_scan_fifo.sv
// First-word-fall-through event FIFO; DEPTH must be a power of two >= 2.
module pio_scan_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/pio_edge_scanner.sv
// Autonomous poller of an edge-capturing PIO; pending edges become FIFO events.
// Define PIO_SCAN_LEVEL_EN to add the live-level read (RD_LVL/WAIT_LVL) to each scan.
//
// state      | meaning
// IDLE       | poll timer counting down; start scan at 0 if enabled and FIFO not full
// RD_EDGE    | edge-capture address presented
// WAIT_EDGE  | edge-capture data sampled; empty scan returns to IDLE
// RD_LVL     | data (level) address presented
// WAIT_LVL   | level data sampled
// CLR        | single write clearing the PIO capture register
// PUSH       | event written to the FIFO, timer reloaded
module pio_edge_scanner
  import pio_scan_pkg::*;
#(
  parameter int   WIDTH      = 12,
  parameter int   POLL_DIV   = 256,
  parameter int   FIFO_DEPTH = 4,
  localparam int  EVW        = LEVEL_EN ? 2 * WIDTH : WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  output logic [1:0]      m_address,
  output logic            m_chipselect,
  output logic            m_write_n,
  output logic [31:0]     m_writedata,
  input  logic [31:0]     m_readdata,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [EVW-1:0]  ev_data,
  output logic            irq
);

  localparam int             TW           = cnt_width(POLL_DIV);
  localparam logic [TW-1:0]  TIMER_RELOAD = TW'(POLL_DIV - 1);

  scan_state_t      state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] edges_q, edges_d;
  logic [1:0]       addr_q, addr_d;
  logic             irq_q;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EVW-1:0]   fifo_wdata;

`ifdef PIO_SCAN_LEVEL_EN
  logic [WIDTH-1:0] level_q, level_d;
`endif

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    edges_d   = edges_q;
    addr_d    = addr_q;
    fifo_push = 1'b0;
`ifdef PIO_SCAN_LEVEL_EN
    level_d   = level_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (timer_q == '0) begin
          // A full FIFO just defers the scan; edges keep accumulating in the PIO.
          if (enable && !fifo_full) begin
            state_d = ST_RD_EDGE;
            addr_d  = PIO_ADDR_EDGE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_RD_EDGE: state_d = ST_WAIT_EDGE;
      ST_WAIT_EDGE: begin
        edges_d = m_readdata[WIDTH-1:0];
        if (m_readdata[WIDTH-1:0] == '0) begin
          state_d = ST_IDLE;
          timer_d = TIMER_RELOAD;
        end else begin
`ifdef PIO_SCAN_LEVEL_EN
          state_d = ST_RD_LVL;
          addr_d  = PIO_ADDR_DATA;
`else
          state_d = ST_CLR;
          addr_d  = PIO_ADDR_EDGE;
`endif
        end
      end
`ifdef PIO_SCAN_LEVEL_EN
      ST_RD_LVL: state_d = ST_WAIT_LVL;
      ST_WAIT_LVL: begin
        level_d = m_readdata[WIDTH-1:0];
        state_d = ST_CLR;
        addr_d  = PIO_ADDR_EDGE;
      end
`endif
      ST_CLR: state_d = ST_PUSH;
      ST_PUSH: begin
        fifo_push = 1'b1;
        state_d   = ST_IDLE;
        timer_d   = TIMER_RELOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= TIMER_RELOAD;
      edges_q <= '0;
      addr_q  <= PIO_ADDR_DATA;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      edges_q <= edges_d;
      addr_q  <= addr_d;
      irq_q   <= !fifo_empty;
    end
  end

`ifdef PIO_SCAN_LEVEL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= '0;
    else       level_q <= level_d;
  end
  assign fifo_wdata = {level_q, edges_q};
`else
  assign fifo_wdata = edges_q;
`endif

  assign fifo_pop = ev_valid && ev_ready;

  pio_scan_fifo #(
    .W     (EVW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (fifo_wdata),
    .data_o  (ev_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ev_valid     = !fifo_empty;
  assign irq          = irq_q;
  assign m_address    = addr_q;
  assign m_chipselect = (state_q == ST_CLR);
  assign m_write_n    = (state_q != ST_CLR);
  assign m_writedata  = '0;

  if (WIDTH < 32) begin : g_unused
    logic unused_rdata;
    assign unused_rdata = ^m_readdata[31:WIDTH];
  end

endmodule

// File: tb/tb_pio_edge_scanner.sv
// Bench for pio_edge_scanner: PIO model, scan-schedule reference model and directed scenarios.
// Honours PIO_SCAN_LEVEL_EN the same way as the design.
module tb_pio_edge_scanner;

  localparam int WIDTH = 12;
  localparam int DIV   = 8;
  localparam int DEPTH = 4;
`ifdef PIO_SCAN_LEVEL_EN
  localparam bit LVL = 1'b1;
`else
  localparam bit LVL = 1'b0;
`endif
  localparam int EVW = LVL ? 2 * WIDTH : WIDTH;
  localparam int CLR_PH = LVL ? 4 : 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pio_rst = 1'b1;
  logic             enable = 1'b0;
  logic             ev_ready = 1'b0;
  logic [1:0]       m_address;
  logic             m_chipselect, m_write_n;
  logic [31:0]      m_writedata, m_readdata;
  logic             ev_valid, irq;
  logic [EVW-1:0]   ev_data;
  logic [WIDTH-1:0] in_port = '0;
  logic [WIDTH-1:0] pio_prev, pio_edge;

  int n_cmp = 0, n_bad = 0;
  int cs_count = 0, valid_cycles = 0;
  bit chk_en = 1'b0;
  logic [EVW-1:0] popped[$];

  always #5 clk = ~clk;

  pio_edge_scanner #(.WIDTH(WIDTH), .POLL_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data), .irq(irq)
  );

  // Edge-capturing PIO: rising edges set capture bits, any write clears them.
  always_ff @(posedge clk or posedge pio_rst) begin
    if (pio_rst) begin
      pio_prev   <= '0;
      pio_edge   <= '0;
      m_readdata <= '0;
    end else begin
      pio_prev <= in_port;
      if (m_chipselect && !m_write_n) pio_edge <= '0;
      else                            pio_edge <= pio_edge | (in_port & ~pio_prev);
      m_readdata <= (m_address == 2'd3) ? {20'd0, pio_edge} :
                    (m_address == 2'd0) ? {20'd0, in_port}  : 32'd0;
    end
  end

  function automatic logic [EVW-1:0] ev_word(input logic [11:0] lvl, input logic [11:0] edg);
    logic [23:0] w;
    w = {lvl, edg};
    return w[EVW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a scan is a numbered sequence of cycles starting when the poll
  // period has elapsed; events queue in order and leave on accepted handshakes.
  logic [EVW-1:0]   mq[$];
  int               ph = -1;
  int               tmr = DIV - 1;
  logic [1:0]       addr_m = 2'd0;
  logic             irq_m = 1'b0;
  logic [WIDTH-1:0] e_m = '0, l_m = '0;

  always @(posedge clk) begin
    int sz;
    if (reset) begin
      mq.delete();
      ph = -1; tmr = DIV - 1; addr_m = 2'd0; irq_m = 1'b0;
    end else begin
      if (ev_valid && ev_ready) popped.push_back(ev_data);
      sz = mq.size();
      irq_m = (sz > 0);
      if (sz > 0 && ev_ready) void'(mq.pop_front());
      if (ph < 0) begin
        if (tmr == 0 && enable && sz < DEPTH) begin ph = 0; addr_m = 2'd3; end
        else if (tmr > 0) tmr--;
      end else if (ph == 0) begin
        e_m = pio_edge; ph = 1;
      end else if (ph == 1) begin
        if (e_m == '0) begin ph = -1; tmr = DIV - 1; end
        else begin ph = 2; addr_m = LVL ? 2'd0 : 2'd3; end
      end else if (ph == CLR_PH + 1) begin
        mq.push_back(ev_word(l_m, e_m)); ph = -1; tmr = DIV - 1;
      end else if (ph == CLR_PH) begin
        ph = CLR_PH + 1;
      end else if (ph == 2) begin
        l_m = in_port; ph = 3;
      end else begin
        ph = 4; addr_m = 2'd3;
      end
    end
  end

  always @(negedge clk) begin
    if (m_chipselect) cs_count++;
    if (ev_valid) valid_cycles++;
    if (chk_en) begin
      chk("m_address",    64'(m_address),    64'(addr_m));
      chk("m_chipselect", 64'(m_chipselect), 64'(ph == CLR_PH));
      chk("m_write_n",    64'(m_write_n),    64'(ph != CLR_PH));
      chk("m_writedata",  64'(m_writedata),  64'd0);
      chk("ev_valid",     64'(ev_valid),     64'(mq.size() > 0));
      chk("ev_data",      64'(ev_data),      64'((mq.size() > 0) ? mq[0] : '0));
      chk("irq",          64'(irq),          64'(irq_m));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k = 0;
    while (!ev_valid && k < budget) begin step(); k++; end
    chk(name, 64'(ev_valid), 64'd1);
  endtask

  task automatic pop1();
    ev_ready = 1'b1; step(); ev_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"},  64'(m_address),    64'd0);
    chk({tag, "_cs"},    64'(m_chipselect), 64'd0);
    chk({tag, "_wn"},    64'(m_write_n),    64'd1);
    chk({tag, "_wdata"}, 64'(m_writedata),  64'd0);
    chk({tag, "_valid"}, 64'(ev_valid),     64'd0);
    chk({tag, "_data"},  64'(ev_data),      64'd0);
    chk({tag, "_irq"},   64'(irq),          64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs0, v0, np0, lat, k;
    step(3);
    pio_rst = 1'b0;
    step(2);
    chk_reset_outputs("rst");

    // Edge pending before reset release: first scan after POLL_DIV idle cycles.
    in_port[0] = 1'b1;
    step(3);
    enable = 1'b1;
    reset  = 1'b0;
    chk_en = 1'b1;
    lat = 0;
    while (!ev_valid && lat < 50) begin step(); lat++; end
    chk("latency", 64'(lat), LVL ? 64'd14 : 64'd12);
    chk("lat_data", 64'(ev_data), 64'(ev_word(12'h001, 12'h001)));
    chk("addr_after_clr", 64'(m_address), 64'd3);
    pop1();
    in_port = '0;

    // Idle scans: nothing pending, no clear writes, no events.
    cs0 = cs_count; v0 = valid_cycles;
    step(40);
    chk("idle_cs", 64'(cs_count - cs0), 64'd0);
    chk("idle_valid", 64'(valid_cycles - v0), 64'd0);
    chk("idle_irq", 64'(irq), 64'd0);

    // Single edge on bit 5.
    cs0 = cs_count;
    in_port[5] = 1'b1;
    wait_valid("single_valid", 40);
    chk("single_data", 64'(ev_data), 64'(ev_word(12'h020, 12'h020)));
    pop1();
    step(30);
    chk("single_cs", 64'(cs_count - cs0), 64'd1);
    chk("single_after", 64'(ev_valid), 64'd0);
    in_port = '0;
    step(5);

    // Backpressure: six bursts, only four fit; the rest merge into a fifth event.
    cs0 = cs_count; np0 = popped.size();
    for (int b = 0; b < 6; b++) begin
      in_port[b] = 1'b1;
      step(2 * DIV + 8);
    end
    chk("bp_cs", 64'(cs_count - cs0), 64'd4);
    chk("bp_valid", 64'(ev_valid), 64'd1);
    ev_ready = 1'b1;
    step(40);
    ev_ready = 1'b0;
    chk("bp_pops", 64'(popped.size() - np0), 64'd5);
    for (int i = 0; i < 5 && np0 + i < popped.size(); i++) begin
      logic [11:0] ee, ll;
      ee = (i < 4) ? 12'(1 << i) : 12'h030;
      ll = (i < 4) ? 12'((1 << (i + 1)) - 1) : 12'h03F;
      chk("bp_event", 64'(popped[np0 + i]), 64'(ev_word(ll, ee)));
    end
    in_port = '0;
    step(5);

    // Push coincides with pop while one event is queued.
    in_port[7] = 1'b1;
    wait_valid("simul_first", 40);
    in_port[8] = 1'b1;
    k = 0;
    while (!m_chipselect && k < 40) begin step(); k++; end
    chk("simul_clr_seen", 64'(m_chipselect), 64'd1);
    step();
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    chk("simul_popped", 64'(popped[popped.size() - 1]), 64'(ev_word(12'h080, 12'h080)));
    chk("simul_valid", 64'(ev_valid), 64'd1);
    chk("simul_data", 64'(ev_data), 64'(ev_word(12'h180, 12'h100)));
    pop1();
    step();
    chk("simul_empty", 64'(ev_valid), 64'd0);
    in_port = '0;
    step(5);

    // Reset in the middle of a scan, before the clear write.
    cs0 = cs_count;
    chk_en = 1'b0;
    reset = 1'b1;
    in_port[3] = 1'b1;
    step(3);
    reset = 1'b0;
    chk_en = 1'b1;
    step(LVL ? 11 : 9);
    chk("mid_pos_addr", 64'(m_address), LVL ? 64'd0 : 64'd3);
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_outputs("mid");
    step(2);
    chk("mid_cs", 64'(cs_count - cs0), 64'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    wait_valid("mid_recover", 40);
    chk("mid_data", 64'(ev_data), 64'(ev_word(12'h008, 12'h008)));
    pop1();
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
